// File: rtl/m20k_read_port_arbiter.sv
// -----------------------------------------------------------------------------
// m20k_read_port_arbiter
//
// Shares one simpleDualPortM20K_20b1024Registered RAM (20-bit x 1024, fixed
// two-cycle registered read) between NUM_REQ read requesters and a single
// writer. The block also sequences a full-memory zero-clear, either after reset
// (CLEAR_ON_RESET) or when initStart is pulsed while running.
//
// Reads are arbitrated round-robin, with at most one grant per cycle. A one-hot
// tag travels down a READ_LATENCY-deep shift register beside each read, so the
// returning RAM data is marked with its owner on respValid. A requester whose
// address matches the write issued in the same cycle is masked for that cycle
// and retried on the next one. As a result it always observes the new data.
//
// Optional build macro:
//   M20K_ARB_STATS_EN : adds the saturating 32-bit counters statGrants and
//                       statHazardStalls.
//
// Ports:
//   clk, rst         single clock; asynchronous active-high reset
//   initStart        pulse in RUN to start a memory clear
//   busy             high while the clear sequence runs
//   reqValid/reqAddr per-requester read requests (10-bit address each, packed)
//   reqReady         one-hot grant (combinational)
//   respValid        one-hot owner of respData, READ_LATENCY cycles after grant
//   respData         RAM read data passthrough
//   wrValid/wrAddr/wrMask/wrData/wrReady   single write channel
//   ramWrite*        RAM write port
//   ramReadEnable/ramReadAddr/ramReadData  RAM read port
//   statGrants, statHazardStalls           (M20K_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module m20k_read_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  initStart,
  output logic                  busy,
  input  logic [NUM_REQ-1:0]    reqValid,
  input  logic [NUM_REQ*10-1:0] reqAddr,
  output logic [NUM_REQ-1:0]    reqReady,
  output logic [NUM_REQ-1:0]    respValid,
  output logic [19:0]           respData,
  input  logic                  wrValid,
  input  logic [9:0]            wrAddr,
  input  logic [1:0]            wrMask,
  input  logic [19:0]           wrData,
  output logic                  wrReady,
  output logic                  ramWriteEnable,
  output logic [9:0]            ramWriteAddr,
  output logic [1:0]            ramWriteMask,
  output logic [19:0]           ramWriteData,
  output logic                  ramReadEnable,
  output logic [9:0]            ramReadAddr,
  input  logic [19:0]           ramReadData
`ifdef M20K_ARB_STATS_EN
  ,
  output logic [31:0]           statGrants,
  output logic [31:0]           statHazardStalls
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] LAST_ADDR = 10'd1023;
  localparam logic [PTR_W:0] NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state;
  logic [9:0]         clearAddr;
  logic [PTR_W-1:0]   rrPtr;

  // Control qualified by reset. The block stays inert on the RAM ports while
  // rst is held, even though the FSM already sits in its reset state.
  logic               inClear;
  logic               inRun;

  logic [NUM_REQ-1:0] hazard;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grantFound;
  logic [PTR_W-1:0]   grantIdx;
  logic [PTR_W-1:0]   nextPtr;
  logic [PTR_W:0]     cand;
  logic [9:0]         grantAddr;

  // One-hot owner tags; respTag_p[READ_LATENCY-1] lines up with ramReadData.
  logic [NUM_REQ-1:0] respTag_p [READ_LATENCY];

  assign inClear = (state == CLEAR) && !rst;
  assign inRun   = (state == RUN) && !rst;
  assign busy    = (state == CLEAR);
  assign wrReady = inRun;

  // ---------------------------------------------------------------------------
  // Hazard masking: a read that targets this cycle's write address must wait
  // one cycle. On its retry the write has landed in the RAM.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard   = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hazard[i]   = reqValid[i] && wrValid && (wrAddr == reqAddr[i*10 +: 10]);
      eligible[i] = reqValid[i] && !hazard[i];
    end
  end

  // Round-robin pick: first eligible requester at or after rrPtr, wrapping.
  always_comb begin
    grant      = '0;
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rrPtr} + (PTR_W + 1)'(k);
      if (cand >= NUM_REQ_EXT) begin
        cand = cand - NUM_REQ_EXT;
      end
      if (inRun && !grantFound && eligible[cand[PTR_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[PTR_W-1:0];
      end
    end
    if (grantFound) begin
      grant[grantIdx] = 1'b1;
    end
  end

  assign nextPtr  = (grantIdx == LAST_REQ) ? '0 : grantIdx + PTR_W'(1);
  assign reqReady = grant;

  always_comb begin
    grantAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantAddr = reqAddr[i*10 +: 10];
      end
    end
  end

  assign ramReadEnable = grantFound;
  assign ramReadAddr   = grantFound ? grantAddr : 10'd0;

  // ---------------------------------------------------------------------------
  // Write port. The clear sequence owns the port in CLEAR. In RUN an accepted
  // write passes through in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramWriteEnable = 1'b0;
    ramWriteAddr   = '0;
    ramWriteMask   = '0;
    ramWriteData   = '0;
    if (inClear) begin
      ramWriteEnable = 1'b1;
      ramWriteAddr   = clearAddr;
      ramWriteMask   = 2'b11;
      ramWriteData   = '0;
    end else if (inRun && wrValid) begin
      ramWriteEnable = 1'b1;
      ramWriteAddr   = wrAddr;
      ramWriteMask   = wrMask;
      ramWriteData   = wrData;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. CLEAR walks every address exactly once and then falls into
  // RUN. initStart is only honoured in RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clearAddr <= '0;
      rrPtr     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clearAddr <= clearAddr + 10'd1;
          if (clearAddr == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (grantFound) begin
            rrPtr <= nextPtr;
          end
          if (initStart) begin
            state     <= CLEAR;
            clearAddr <= '0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 .. p(READ_LATENCY-1): owner tag follows the RAM read pipeline.
  // Reads already in flight when a clear starts still complete. A reset drops
  // them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        respTag_p[s] <= '0;
      end
    end else begin
      respTag_p[0] <= grant;
      for (int s = 1; s < READ_LATENCY; s++) begin
        respTag_p[s] <= respTag_p[s-1];
      end
    end
  end

  assign respValid = respTag_p[READ_LATENCY-1];
  // The RAM drives zero when its read was not enabled, so no gating is needed.
  assign respData  = ramReadData;

`ifdef M20K_ARB_STATS_EN
  logic anyHazard;

  assign anyHazard = inRun && (|hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statGrants       <= '0;
      statHazardStalls <= '0;
    end else if ((state == RUN) && initStart) begin
      // Counters restart with each clear.
      statGrants       <= '0;
      statHazardStalls <= '0;
    end else begin
      if (grantFound && (statGrants != '1)) begin
        statGrants <= statGrants + 32'd1;
      end
      if (anyHazard && (statHazardStalls != '1)) begin
        statHazardStalls <= statHazardStalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_m20k_read_port_arbiter.sv
`timescale 1ns/1ps
module tb_m20k_read_port_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            initStart;
  logic            busy;
  logic [N-1:0]    reqValid;
  logic [N*10-1:0] reqAddr;
  logic [N-1:0]    reqReady;
  logic [N-1:0]    respValid;
  logic [19:0]     respData;
  logic            wrValid;
  logic [9:0]      wrAddr;
  logic [1:0]      wrMask;
  logic [19:0]     wrData;
  logic            wrReady;
  logic            ramWriteEnable;
  logic [9:0]      ramWriteAddr;
  logic [1:0]      ramWriteMask;
  logic [19:0]     ramWriteData;
  logic            ramReadEnable;
  logic [9:0]      ramReadAddr;
  logic [19:0]     ramReadData;

  m20k_read_port_arbiter #(
    .NUM_REQ(N),
    .READ_LATENCY(2),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .initStart(initStart),
    .busy(busy),
    .reqValid(reqValid),
    .reqAddr(reqAddr),
    .reqReady(reqReady),
    .respValid(respValid),
    .respData(respData),
    .wrValid(wrValid),
    .wrAddr(wrAddr),
    .wrMask(wrMask),
    .wrData(wrData),
    .wrReady(wrReady),
    .ramWriteEnable(ramWriteEnable),
    .ramWriteAddr(ramWriteAddr),
    .ramWriteMask(ramWriteMask),
    .ramWriteData(ramWriteData),
    .ramReadEnable(ramReadEnable),
    .ramReadAddr(ramReadAddr),
    .ramReadData(ramReadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM stand-in: two-cycle registered read, zero output when the read was not enabled.
  logic [19:0] ramMem [1024];
  logic [19:0] rdStage1;
  logic [19:0] rdStage2;
  assign ramReadData = rdStage2;

  initial begin
    rdStage1 <= '0;
    rdStage2 <= '0;
    for (int i = 0; i < 1024; i++) ramMem[i] <= 20'($urandom);
  end

  always @(posedge clk) begin
    rdStage1 <= ramReadEnable ? ramMem[ramReadAddr] : 20'd0;
    rdStage2 <= rdStage1;
    if (ramWriteEnable) begin
      if (ramWriteMask[0]) ramMem[ramWriteAddr][9:0]   <= ramWriteData[9:0];
      if (ramWriteMask[1]) ramMem[ramWriteAddr][19:10] <= ramWriteData[19:10];
    end
  end

  // Reference model state
  logic [19:0] refMem [1024];
  int          mRrPtr = 0;

  typedef struct {
    logic [N-1:0] who;
    logic [19:0]  data;
    int           due;
  } exp_t;
  exp_t expQ[$];
  exp_t monE;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && (respValid != '0)) begin
      if (expQ.size() == 0) begin
        check("resp_unexpected", 64'(respValid), 64'd0);
      end else begin
        monE = expQ.pop_front();
        check("resp_owner", 64'(respValid), 64'(monE.who));
        check("resp_data", 64'(respData), 64'(monE.data));
        check("resp_cycle", 64'(cyc), 64'(monE.due));
      end
    end
  end

  always @(posedge rst) expQ.delete();

  task automatic zeroRef();
    for (int i = 0; i < 1024; i++) refMem[i] = '0;
  endtask

  task automatic idle();
    reqValid  = '0;
    reqAddr   = '0;
    wrValid   = 1'b0;
    wrAddr    = '0;
    wrMask    = '0;
    wrData    = '0;
    initStart = 1'b0;
  endtask

  // One RUN cycle: predict grant and port activity from the arbitration rules.
  task automatic runCycle(output logic [N-1:0] seen);
    logic [N-1:0] elig;
    logic [N-1:0] expGrant;
    logic [10:0]  expRd;
    logic [9:0]   a;
    int           g;
    @(negedge clk);
    seen = reqReady;
    g = -1;
    for (int i = 0; i < N; i++)
      elig[i] = reqValid[i] && !(wrValid && (wrAddr == reqAddr[i*10 +: 10]));
    for (int k = 0; k < N; k++)
      if (g < 0 && elig[(mRrPtr + k) % N]) g = (mRrPtr + k) % N;
    expGrant = '0;
    expRd    = '0;
    a        = '0;
    if (g >= 0) begin
      expGrant[g] = 1'b1;
      a           = reqAddr[g*10 +: 10];
      expRd       = {1'b1, a};
    end
    check("reqReady", 64'(reqReady), 64'(expGrant));
    check("read_port", 64'({ramReadEnable, ramReadAddr}), 64'(expRd));
    check("run_flags", 64'({busy, wrReady}), 64'(2'b01));
    check("wr_enable", 64'(ramWriteEnable), 64'(wrValid));
    if (wrValid)
      check("wr_port", 64'({ramWriteAddr, ramWriteMask, ramWriteData}),
            64'({wrAddr, wrMask, wrData}));
    if (g >= 0) begin
      expQ.push_back('{who: expGrant, data: refMem[a], due: cyc + 2});
      mRrPtr = (g + 1) % N;
    end
    if (wrValid) begin
      if (wrMask[0]) refMem[wrAddr][9:0]   = wrData[9:0];
      if (wrMask[1]) refMem[wrAddr][19:10] = wrData[19:10];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("clear_cycle",
            64'({busy, ramWriteEnable, ramWriteAddr, ramWriteMask, ramWriteData,
                 reqReady, wrReady, ramReadEnable}),
            64'({1'b1, 1'b1, 10'(i), 2'b11, 20'd0, 4'b0000, 1'b0, 1'b0}));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearExit();
    @(negedge clk);
    check("clear_exit", 64'({busy, wrReady}), 64'(2'b01));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] seen;
  logic [N-1:0] dummy;

  initial begin
    idle();
    rst = 1'b1;
    zeroRef();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          64'({busy, respValid, reqReady, wrReady, ramWriteEnable, ramReadEnable}),
          64'({1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mRrPtr = 0;

    // Power-on clear
    clearCheck(1024);
    zeroRef();
    clearExit();

    // Write then read back
    wrValid = 1'b1; wrAddr = 10'd5; wrMask = 2'b11; wrData = 20'h12345;
    runCycle(dummy);
    idle();
    reqValid = 4'b0001; reqAddr[9:0] = 10'd5;
    runCycle(seen);
    check("rd5_grant", 64'(seen), 64'(4'b0001));
    idle();
    repeat (3) runCycle(dummy);

    // Bring pointer to 0, then full contention
    reqValid = 4'b1000; reqAddr[39:30] = 10'd50;
    runCycle(dummy);
    for (int i = 0; i < N; i++) reqAddr[i*10 +: 10] = 10'(100 + i);
    reqValid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      runCycle(seen);
      check("rr_order", 64'(seen), 64'(4'b0001 << (k % 4)));
    end
    idle();
    repeat (3) runCycle(dummy);

    // Write/read hazard on the same address
    wrValid = 1'b1; wrAddr = 10'd7; wrMask = 2'b11; wrData = 20'hABCDE;
    reqValid = 4'b0110; reqAddr[19:10] = 10'd7; reqAddr[29:20] = 10'd9;
    runCycle(seen);
    check("hazard_first", 64'(seen), 64'(4'b0100));
    wrValid = 1'b0;
    reqValid = 4'b0010;
    runCycle(seen);
    check("hazard_retry", 64'(seen), 64'(4'b0010));
    idle();
    repeat (3) runCycle(dummy);

    // Randomized traffic on a small address window to provoke hazards
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        reqValid[i] = ($urandom_range(0, 3) != 0);
        reqAddr[i*10 +: 10] = 10'($urandom_range(0, 15));
      end
      wrValid = ($urandom_range(0, 2) != 0);
      wrAddr  = 10'($urandom_range(0, 15));
      wrMask  = 2'($urandom_range(0, 3));
      wrData  = 20'($urandom);
      runCycle(dummy);
    end
    idle();
    repeat (3) runCycle(dummy);

    // initStart during streaming reads; write in the same cycle is still issued
    for (int i = 0; i < N; i++) reqAddr[i*10 +: 10] = 10'($urandom_range(0, 15));
    reqValid = 4'b1111;
    runCycle(dummy);
    initStart = 1'b1;
    wrValid = 1'b1; wrAddr = 10'd200; wrMask = 2'b11; wrData = 20'h55AA5;
    runCycle(dummy);
    wrValid = 1'b0;
    clearCheck(1024);   // requests and initStart held high throughout
    idle();
    zeroRef();
    clearExit();

    // Asynchronous reset in the middle of a clear
    initStart = 1'b1;
    runCycle(dummy);
    initStart = 1'b0;
    clearCheck(300);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_clear", 64'({respValid, ramWriteEnable, busy, reqReady}),
          64'({4'b0000, 1'b0, 1'b1, 4'b0000}));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mRrPtr = 0;
    clearCheck(1024);
    zeroRef();
    clearExit();

    // Reset with a read in flight drops its response
    reqValid = 4'b0001; reqAddr[9:0] = 10'd5;
    runCycle(dummy);
    idle();
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flushed_resp", 64'(respValid), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
